// File: rtl/receive_all_if.sv
// Board-to-board receive link: the peer's 4-phase Request/Ack handshake with
// its 6-bit data bus, the decoded message toward GameControl, and the
// receiver's debug view of its FSM.
interface receive_all_if;
    // Handshake (4-phase, return-to-zero):
    //   the sender puts a word on inter_data_in, then raises Request_in;
    //   the receiver samples the word and raises Ack_out;
    //   the sender drops Request_in, and the receiver then drops Ack_out.
    //   inter_data_in is held stable for as long as Request_in is high.
    //   recv_valid, recv_error and interboard_rst_out are single-cycle
    //   strobes with no back-pressure.
    logic       Request_in;
    logic [5:0] inter_data_in;
    logic       Ack_out;

    logic       recv_valid;
    logic [3:0] recv_msg_type;
    logic [4:0] recv_block_x;
    logic [2:0] recv_block_y;
    logic [5:0] recv_card;
    logic [2:0] recv_sel_len;
    logic       recv_move_dir;
    logic       recv_error;
    logic       interboard_rst_out;

    // Debug view: FSM state (0 = WAIT_REQ_UP, 1 = WAIT_REQ_DOWN) and word index.
    logic       dbg_state;
    logic [2:0] dbg_word_idx;

    // Sending side (the peer board, or a testbench).
    modport master (
        output Request_in, inter_data_in,
        input  Ack_out, recv_valid, recv_msg_type, recv_block_x, recv_block_y,
               recv_card, recv_sel_len, recv_move_dir, recv_error,
               interboard_rst_out, dbg_state, dbg_word_idx
    );

    // Receiving side (receive_all).
    modport slave (
        input  Request_in, inter_data_in,
        output Ack_out, recv_valid, recv_msg_type, recv_block_x, recv_block_y,
               recv_card, recv_sel_len, recv_move_dir, recv_error,
               interboard_rst_out, dbg_state, dbg_word_idx
    );
endinterface

// File: rtl/receive_all.sv
// Receive stage for the six-word board-to-board message. It synchronizes the
// peer's Request, acknowledges each word, and reassembles the words into
// parallel fields. It also flags the peer reset word, and aborts a message
// that stalls between words.
module receive_all #(
    parameter int         SYNC_STAGES    = 2,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [5:0] RST_WORD       = 6'b111111
) (
    input  logic          clk,
    input  logic          rst,
    receive_all_if.slave  bus
);
    typedef enum logic {
        WAIT_REQ_UP   = 1'b0,
        WAIT_REQ_DOWN = 1'b1
    } state_t;

    localparam int         CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit         WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    state_t        state, state_d;
    logic [2:0]    word_idx, idx_d;
    logic [CW-1:0] wd_cnt, cnt_d;
    logic          rst_hs, rst_hs_d;   // current handshake carries the peer reset word
    logic          cap_en;
    logic [2:0]    cap_idx;
    logic          done;
    logic          expire;
    logic          err_d, prst_d;

    // Only the bits each field uses are kept from each captured word.
    logic [3:0] b_msg;
    logic [4:0] b_x;
    logic [2:0] b_y;
    logic [5:0] b_card;
    logic [2:0] b_sel;
    logic       b_dir;

    logic ack_q, valid_q, err_q, prst_q;

    assign req_s = sync_q[SYNC_STAGES-1];

    // Request synchronizer: shift the raw Request through SYNC_STAGES flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.Request_in};
    end

    // Next-state logic: handshake sequencing, word counting, watchdog, strobes.
    always_comb begin
        state_d  = state;
        idx_d    = word_idx;
        cnt_d    = wd_cnt;
        rst_hs_d = rst_hs;
        cap_en   = 1'b0;
        cap_idx  = word_idx;
        done     = 1'b0;
        expire   = 1'b0;
        err_d    = 1'b0;
        prst_d   = 1'b0;
        case (state)
            WAIT_REQ_UP: begin
                if (WD_EN && word_idx != 3'd0) begin
                    if (wd_cnt == TO_LAST) begin
                        expire = 1'b1;
                        idx_d  = 3'd0;
                        cnt_d  = '0;
                        err_d  = 1'b1;
                    end else begin
                        cnt_d = wd_cnt + CW'(1);
                    end
                end
                if (req_s) begin
                    // An expiring watchdog wins: the arriving word starts a new message.
                    state_d = WAIT_REQ_DOWN;
                    cnt_d   = '0;
                    cap_idx = expire ? 3'd0 : word_idx;
                    if (cap_idx == 3'd0 && bus.inter_data_in == RST_WORD) begin
                        prst_d   = 1'b1;
                        rst_hs_d = 1'b1;
                    end else begin
                        cap_en   = 1'b1;
                        rst_hs_d = 1'b0;
                    end
                end
            end
            WAIT_REQ_DOWN: begin
                if (!req_s) begin
                    state_d  = WAIT_REQ_UP;
                    rst_hs_d = 1'b0;
                    if (rst_hs) begin
                        idx_d = 3'd0;
                    end else if (word_idx == 3'd5) begin
                        idx_d = 3'd0;
                        done  = 1'b1;
                    end else begin
                        idx_d = word_idx + 3'd1;
                    end
                end
            end
            default: state_d = WAIT_REQ_UP;
        endcase
    end

    // FSM, watchdog and strobe registers. Ack mirrors the next state so it is high exactly in WAIT_REQ_DOWN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WAIT_REQ_UP;
            word_idx <= 3'd0;
            wd_cnt   <= '0;
            rst_hs   <= 1'b0;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            prst_q   <= 1'b0;
        end else begin
            state    <= state_d;
            word_idx <= idx_d;
            wd_cnt   <= cnt_d;
            rst_hs   <= rst_hs_d;
            ack_q    <= (state_d == WAIT_REQ_DOWN);
            valid_q  <= done;
            err_q    <= err_d;
            prst_q   <= prst_d;
        end
    end

    // Word buffer: store the used bits of each captured word in its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_msg  <= '0;
            b_x    <= '0;
            b_y    <= '0;
            b_card <= '0;
            b_sel  <= '0;
            b_dir  <= 1'b0;
        end else if (cap_en) begin
            case (cap_idx)
                3'd0:    b_msg  <= bus.inter_data_in[3:0];
                3'd1:    b_x    <= bus.inter_data_in[4:0];
                3'd2:    b_y    <= bus.inter_data_in[2:0];
                3'd3:    b_card <= bus.inter_data_in;
                3'd4:    b_sel  <= bus.inter_data_in[2:0];
                default: b_dir  <= bus.inter_data_in[0];
            endcase
        end
    end

    // Output fields: load the whole message at completion and hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.recv_msg_type <= '0;
            bus.recv_block_x  <= '0;
            bus.recv_block_y  <= '0;
            bus.recv_card     <= '0;
            bus.recv_sel_len  <= '0;
            bus.recv_move_dir <= 1'b0;
        end else if (done) begin
            bus.recv_msg_type <= b_msg;
            bus.recv_block_x  <= b_x;
            bus.recv_block_y  <= b_y;
            bus.recv_card     <= b_card;
            bus.recv_sel_len  <= b_sel;
            bus.recv_move_dir <= b_dir;
        end
    end

    assign bus.Ack_out            = ack_q;
    assign bus.recv_valid         = valid_q;
    assign bus.recv_error         = err_q;
    assign bus.interboard_rst_out = prst_q;
    assign bus.dbg_state          = state;
    assign bus.dbg_word_idx       = word_idx;
endmodule

// File: tb/tb_receive_all.sv
// Bench for receive_all: a sender driver, a message-level reference model
// feeding an expected queue, and an independent output monitor.
module tb_receive_all;
    localparam int SYNC = 2;
    localparam int TO   = 50;
    localparam int LAT  = SYNC + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    receive_all_if bus ();

    receive_all #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .RST_WORD(6'h3F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: words of the message in progress, expected outputs.
    int          partial[$];
    logic [21:0] exp_q[$];
    int          rst_exp = 0, rst_seen = 0;
    int          err_exp = 0, err_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a word arrives; returns 1 if it is the peer reset word.
    function automatic bit model_word(input logic [5:0] d);
        logic [21:0] e;
        if (partial.size() == 0 && d == 6'h3F) begin
            rst_exp++;
            return 1'b1;
        end
        partial.push_back(int'(d));
        if (partial.size() == 6) begin
            e = {4'(partial[0] % 16), 5'(partial[1] % 32), 3'(partial[2] % 8),
                 6'(partial[3]), 3'(partial[4] % 8), 1'(partial[5] % 2)};
            exp_q.push_back(e);
            partial.delete();
        end
        return 1'b0;
    endfunction

    // Driver: one complete 4-phase handshake, checking Ack latencies and the reset strobe.
    task automatic send_word(input logic [5:0] d);
        int n;
        bit is_rst;
        bus.inter_data_in = d;
        @(negedge clk);
        bus.Request_in = 1'b1;
        is_rst = model_word(d);
        n = 0;
        while (!bus.Ack_out && n < 20) begin @(negedge clk); n++; end
        check("ack_rise_latency", n, LAT);
        check("peer_rst_strobe", bus.interboard_rst_out, is_rst);
        bus.Request_in = 1'b0;
        n = 0;
        while (bus.Ack_out && n < 20) begin @(negedge clk); n++; end
        check("ack_fall_latency", n, LAT);
    endtask

    task automatic send_msg(input logic [5:0] w0, w1, w2, w3, w4, w5, input bit gaps);
        logic [5:0] w[6];
        w = '{w0, w1, w2, w3, w4, w5};
        for (int i = 0; i < 6; i++) begin
            if (gaps) repeat ($urandom_range(0, 4)) @(negedge clk);
            send_word(w[i]);
        end
    endtask

    function automatic logic [21:0] fields();
        return {bus.recv_msg_type, bus.recv_block_x, bus.recv_block_y,
                bus.recv_card, bus.recv_sel_len, bus.recv_move_dir};
    endfunction

    // Monitor: compare each completed message with the model and count strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.recv_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got fields %0h expected no message", fields());
                end else begin
                    check("message_fields", fields(), exp_q.pop_front());
                end
            end
            if (bus.recv_error)         err_seen++;
            if (bus.interboard_rst_out) rst_seen++;
        end
    end

    initial begin
        int first_err;
        bit glitch_ok;
        bus.Request_in    = 1'b0;
        bus.inter_data_in = 6'd0;
        repeat (3) @(negedge clk);
        check("reset_ack", bus.Ack_out, 0);
        check("reset_valid", bus.recv_valid, 0);
        check("reset_error", bus.recv_error, 0);
        check("reset_peer_rst", bus.interboard_rst_out, 0);
        check("reset_fields", fields(), 0);
        check("reset_word_idx", bus.dbg_word_idx, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed message.
        send_msg(6'h03, 6'h11, 6'h05, 6'h2A, 6'h04, 6'h01, 1'b0);
        repeat (2) @(negedge clk);
        check("direct_fields", fields(), {4'd3, 5'd17, 3'd5, 6'd42, 3'd4, 1'b1});

        // Peer reset word, then a normal message.
        send_word(6'h3F);
        check("peer_rst_idx", bus.dbg_word_idx, 0);
        send_msg(6'h05, 6'h02, 6'h01, 6'h10, 6'h03, 6'h00, 1'b0);

        // Upper-bit masking; 0x3F as a card is ordinary data.
        send_msg(6'h37, 6'h2B, 6'h3D, 6'h3F, 6'h3E, 6'h02, 1'b0);
        repeat (2) @(negedge clk);
        check("mask_msg_type", bus.recv_msg_type, 7);
        check("mask_block_y", bus.recv_block_y, 5);
        check("mask_card", bus.recv_card, 63);

        // Watchdog: three words, then idle.
        send_word(6'h01);
        send_word(6'h02);
        send_word(6'h03);
        first_err = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.recv_error && first_err == 0) first_err = i;
        end
        partial.delete();
        err_exp++;
        check("timeout_cycle", first_err, TO);
        send_msg(6'h09, 6'h1F, 6'h07, 6'h20, 6'h06, 6'h01, 1'b0);

        // Request glitch shorter than one clock period.
        @(negedge clk);
        bus.Request_in = 1'b1;
        #2 bus.Request_in = 1'b0;
        glitch_ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.Ack_out) glitch_ok = 1'b0;
        end
        check("glitch_ignored", glitch_ok, 1);

        // Asynchronous reset while Ack is high on word 4.
        send_word(6'h01);
        send_word(6'h02);
        send_word(6'h03);
        send_word(6'h04);
        bus.inter_data_in = 6'h05;
        @(negedge clk);
        bus.Request_in = 1'b1;
        for (int n = 0; n < 20 && !bus.Ack_out; n++) @(negedge clk);
        check("midrst_ack_up", bus.Ack_out, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_ack_drop", bus.Ack_out, 0);
        check("midrst_fields", fields(), 0);
        partial.delete();
        @(negedge clk);
        bus.Request_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_msg(6'h0C, 6'h15, 6'h03, 6'h2D, 6'h02, 6'h00, 1'b0);

        // Randomized messages with random gaps; word 0 may be the reset word.
        for (int m = 0; m < 20; m++) begin
            send_msg(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                     6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                     6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b1);
        end
        // Leftover partial (after random reset words) must never complete.
        repeat (TO + 10) @(negedge clk);
        if (partial.size() != 0) begin
            partial.delete();
            err_exp++;
        end

        check("pending_messages", exp_q.size(), 0);
        check("error_pulses", err_seen, err_exp);
        check("peer_rst_pulses", rst_seen, rst_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
